uart_tx_inject: RTL and testbench
=================================

Name: uart_tx_inject

Overview:
- UART 8N1 transmitter that drives serial bytes into the SoC `RxD` pin. It is the opposite direction of the `uartprint` receive path.
- Accepts bytes over a valid/ready interface into a small FIFO, then serialises them LSB-first at a fixed baud rate.
- Used in the single-core harness, and usable as RTL, to feed stimulus/commands to the BIOS/firmware UART.

Parameters:
- `BAUD`, 115200, line bit rate in bit/s.
- `FREQ`, 74_250_000, clk_i frequency in Hz. Bit period `DIV = (FREQ + BAUD/2) / BAUD` cycles; this gives 645 at the defaults. Must be ≥ 2.
- `FIFO_DEPTH`, 8, byte FIFO entries. Power of two, ≥ 2.
- `STOP_BITS`, 1, number of stop bits (1 or 2).

Ports:
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `active_i`  in  1  enable. When 0, no new frame starts; a frame in flight completes.
- `data_i`  in  8  byte to send.
- `valid_i`  in  1  `data_i` is valid.
- `ready_o`  out  1  FIFO can accept a byte. A byte is accepted on a cycle where `valid_i & ready_o`.
- `tx_o`  out  1  serial line; idles high.
- `busy_o`  out  1  high while a frame is on the line (state != IDLE).
- `level_o`  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

Behaviour:
- **Reset** (`rst_ni` = 0, takes effect immediately, async):
  - `tx_o` = 1, `busy_o` = 0, `level_o` = 0, FIFO emptied, state = IDLE, bit counters = 0.
  - Inputs are ignored while reset is asserted.
  - Reset mid-frame aborts the frame: line goes high at once and the partial byte is lost.
- **ready_o** = (`level_o` != FIFO_DEPTH), combinational from registered occupancy.
  - Push when full is impossible.
  - Push and pop in the same cycle leave `level_o` unchanged.
- **FSM states**: IDLE, START, DATA, STOP. One baud counter counts 0..DIV-1; a bit ends when the counter = DIV-1.
- **IDLE**: `tx_o` = 1. If `active_i` & FIFO not empty: pop the head into the shift register and go to START.
- **START**: `tx_o` = 0 for DIV cycles, then go to DATA with bit index 0.
- **DATA**: `tx_o` = shreg[0] for DIV cycles per bit, shifting right after each bit. After bit index 7, go to STOP.
- **STOP**: `tx_o` = 1 for STOP_BITS×DIV cycles.
  - On the last cycle, if `active_i` & FIFO not empty: pop and go directly to START. There are zero idle cycles between back-to-back frames.
  - Otherwise go to IDLE.
- **Latency**:
  - Byte pushed at cycle N into an empty FIFO with IDLE and `active_i` = 1: popped at N+1, `tx_o` falls at N+2.
  - Frame length = (9 + STOP_BITS)×DIV cycles exactly.
- **Outputs**: `tx_o` is driven from a register, so it is glitch-free.
- **active_i deasserted**:
  - Mid-frame: the current frame finishes normally; the FSM returns to IDLE and holds the FIFO contents.
  - Reasserted: transmission resumes at the next IDLE evaluation.
- **Order and overflow**: FIFO is first-in first-out; read/write pointers wrap modulo FIFO_DEPTH. No overflow is possible because of `ready_o`. Pop only occurs when not empty.

Decomposition:
- Package `uart_pkg`:
  - state enum (IDLE/START/DATA/STOP);
  - function computing DIV from FREQ/BAUD with rounding;
  - constant for data bits (8).
  - Shared with the receive model.
- Sub-module `uart_tx_fifo`: synchronous FIFO (async active-low reset) with push/pop, full/empty and level outputs, parameterised by depth and width.
- The top level holds the FSM, baud counter, bit index and shift register.

Test Plan:
- All tests use FREQ=1600, BAUD=100 (DIV=16).
- Single byte 0x55, `active_i`=1 → `tx_o` low from push+2 for 16 cycles, then bits 1,0,1,0,1,0,1,0 at 16 cycles each, then high. `busy_o` high for exactly 160 cycles.
- Back-to-back 0xA5, 0x3C pushed on consecutive cycles → second start bit begins the cycle after the first frame's stop bit ends. Total 320 cycles of `busy_o`, no idle gap. Decoded bytes are 0xA5 then 0x3C.
- Fill: push 9 bytes with `active_i`=0 → `ready_o` drops after the 8th (`level_o`=8). The 9th is not accepted; `tx_o` stays 1.
- Raise `active_i` → 8 frames sent in order; `ready_o` rises after the first pop.
- `active_i` dropped mid-frame on byte 0xFF → that frame completes (160 cycles); no further frame starts while the FIFO still holds its remaining bytes.
- Assert `rst_ni`=0 during DATA bit 3 → `tx_o`=1 and `busy_o`=0 in the same cycle, `level_o`=0. After release, nothing is transmitted until a new push.
- STOP_BITS=2, byte 0x00 → stop high for 32 cycles; frame = 176 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// UART shared definitions: transmitter FSM states, data width and the
// bit-period calculation. Also used by the receive-side model.
package uart_pkg;

    // Data bits per frame (8N1).
    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } txState_e;

    // Clock cycles per bit, rounded to the nearest integer.
    function automatic int calcDiv(input int freq, input int baud);
        return (freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-in first-out buffer with show-ahead read.
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset (empties the FIFO)
//   push_i   : write data_i (ignored when full)
//   data_i   : write data
//   pop_i    : drop the head entry (ignored when empty)
//   data_o   : current head entry, valid whenever empty_o is low
//   full_o   : occupancy equals DEPTH
//   empty_o  : occupancy is zero
//   level_o  : current occupancy
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               data_i,
    input  logic                           pop_i,
    output logic [WIDTH-1:0]               data_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] memArray [DEPTH];
    logic [PTR_W-1:0] wrPtrReg;
    logic [PTR_W-1:0] rdPtrReg;
    logic [LVL_W-1:0] levelReg;
    logic             doPush;
    logic             doPop;

    assign full_o  = (levelReg == LVL_W'(DEPTH));
    assign empty_o = (levelReg == '0);
    assign level_o = levelReg;
    assign doPush  = push_i & ~full_o;
    assign doPop   = pop_i & ~empty_o;

    // Head is read combinationally so the transmitter can load it in the
    // same cycle it decides to start a frame.
    assign data_o = memArray[rdPtrReg];

    // Storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk_i) begin
        if (doPush) begin
            memArray[wrPtrReg] <= data_i;
        end
    end

    // DEPTH is a power of two, so pointer increments wrap on their own.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            levelReg <= '0;
        end else begin
            if (doPush) begin
                wrPtrReg <= wrPtrReg + PTR_W'(1);
            end
            if (doPop) begin
                rdPtrReg <= rdPtrReg + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   levelReg <= levelReg + LVL_W'(1);
                2'b01:   levelReg <= levelReg - LVL_W'(1);
                default: levelReg <= levelReg;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_inject.sv
// UART 8N1 transmitter feeding serial bytes into the SoC RxD pin.
// Bytes enter a FIFO over valid/ready and leave LSB-first at BAUD.
//   clk_i    : system clock (FREQ Hz)
//   rst_ni   : asynchronous active-low reset; aborts any frame in flight
//   active_i : allows new frames to start; a running frame always completes
//   data_i   : byte to send
//   valid_i  : data_i is valid; accepted when valid_i & ready_o
//   ready_o  : FIFO has room
//   tx_o     : serial line, idles high, driven from a register
//   busy_o   : a frame is on the line
//   level_o  : FIFO occupancy
module uart_tx_inject
    import uart_pkg::*;
#(
    parameter int BAUD       = 115200,
    parameter int FREQ       = 74_250_000,
    parameter int FIFO_DEPTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              active_i,
    input  logic [7:0]                        data_i,
    input  logic                              valid_i,
    output logic                              ready_o,
    output logic                              tx_o,
    output logic                              busy_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   level_o
);

    localparam int               DIV       = calcDiv(FREQ, BAUD);
    localparam int               CNT_W     = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [2:0]       LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);

    txState_e         stateReg,   stateNext;
    logic [CNT_W-1:0] baudCntReg, baudCntNext;
    logic [2:0]       bitIdxReg,  bitIdxNext;
    logic [7:0]       shiftReg,   shiftNext;
    logic             txReg,      txNext;

    logic             fifoPop;
    logic             fifoFull;
    logic             fifoEmpty;
    logic [7:0]       fifoHead;
    logic             bitEnd;
    logic             canStart;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) txFifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (valid_i),
        .data_i  (data_i),
        .pop_i   (fifoPop),
        .data_o  (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .level_o (level_o)
    );

    assign ready_o  = ~fifoFull;
    assign busy_o   = (stateReg != IDLE);
    assign tx_o     = txReg;
    assign bitEnd   = (baudCntReg == CNT_LAST);
    assign canStart = active_i & ~fifoEmpty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stateReg   <= IDLE;
            baudCntReg <= '0;
            bitIdxReg  <= '0;
            shiftReg   <= '0;
            txReg      <= 1'b1;
        end else begin
            stateReg   <= stateNext;
            baudCntReg <= baudCntNext;
            bitIdxReg  <= bitIdxNext;
            shiftReg   <= shiftNext;
            txReg      <= txNext;
        end
    end

    // bitIdxReg counts data bits in DATA and stop bits in STOP.
    always_comb begin
        stateNext   = stateReg;
        baudCntNext = baudCntReg;
        bitIdxNext  = bitIdxReg;
        shiftNext   = shiftReg;
        fifoPop     = 1'b0;

        case (stateReg)
            IDLE: begin
                baudCntNext = '0;
                bitIdxNext  = '0;
                if (canStart) begin
                    fifoPop   = 1'b1;
                    shiftNext = fifoHead;
                    stateNext = START;
                end
            end
            START: begin
                if (bitEnd) begin
                    baudCntNext = '0;
                    bitIdxNext  = '0;
                    stateNext   = DATA;
                end else begin
                    baudCntNext = baudCntReg + CNT_W'(1);
                end
            end
            DATA: begin
                if (bitEnd) begin
                    baudCntNext = '0;
                    shiftNext   = shiftReg >> 1;
                    if (bitIdxReg == LAST_DATA) begin
                        bitIdxNext = '0;
                        stateNext  = STOP;
                    end else begin
                        bitIdxNext = bitIdxReg + 3'd1;
                    end
                end else begin
                    baudCntNext = baudCntReg + CNT_W'(1);
                end
            end
            STOP: begin
                if (bitEnd) begin
                    baudCntNext = '0;
                    if (bitIdxReg == LAST_STOP) begin
                        bitIdxNext = '0;
                        // Chain straight into the next start bit so
                        // back-to-back frames have no idle gap.
                        if (canStart) begin
                            fifoPop   = 1'b1;
                            shiftNext = fifoHead;
                            stateNext = START;
                        end else begin
                            stateNext = IDLE;
                        end
                    end else begin
                        bitIdxNext = bitIdxReg + 3'd1;
                    end
                end else begin
                    baudCntNext = baudCntReg + CNT_W'(1);
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Line level follows the next state so tx_o changes on the same edge
    // the FSM enters that state.
    always_comb begin
        txNext = 1'b1;
        case (stateNext)
            START:   txNext = 1'b0;
            DATA:    txNext = shiftNext[0];
            default: txNext = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_inject.sv
module tb_uart_tx_inject;

    localparam int DIV = 16;

    logic       clk;
    logic       rst_n;

    logic       active1, valid1, ready1, tx1, busy1;
    logic [7:0] data1;
    logic [3:0] level1;

    logic       active2, valid2, ready2, tx2, busy2;
    logic [7:0] data2;
    logic [3:0] level2;

    int nChecks = 0;
    int nPass   = 0;

    uart_tx_inject #(.BAUD(100), .FREQ(1600), .FIFO_DEPTH(8), .STOP_BITS(1)) dut1 (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .active_i (active1),
        .data_i   (data1),
        .valid_i  (valid1),
        .ready_o  (ready1),
        .tx_o     (tx1),
        .busy_o   (busy1),
        .level_o  (level1)
    );

    uart_tx_inject #(.BAUD(100), .FREQ(1600), .FIFO_DEPTH(8), .STOP_BITS(2)) dut2 (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .active_i (active2),
        .data_i   (data2),
        .valid_i  (valid2),
        .ready_o  (ready2),
        .tx_o     (tx2),
        .busy_o   (busy2),
        .level_o  (level2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        nChecks++;
        if (got == exp) begin
            nPass++;
            $display("check %s: got %0d expected %0d ok", tag, got, exp);
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Entered on the negedge of the first start-bit cycle; every cycle of the
    // frame is sampled and the task returns on the negedge right after it.
    task automatic watchFrame(input int sel, input logic [7:0] b, input int stopBits,
                              input string tag);
        int   nBits;
        int   good;
        int   busyGood;
        logic expBit;
        logic txNow;
        logic busyNow;
        nBits    = 9 + stopBits;
        busyGood = 0;
        for (int k = 0; k < nBits; k++) begin
            if (k == 0)      expBit = 1'b0;
            else if (k <= 8) expBit = b[k-1];
            else             expBit = 1'b1;
            good = 0;
            for (int c = 0; c < DIV; c++) begin
                txNow   = (sel == 2) ? tx2 : tx1;
                busyNow = (sel == 2) ? busy2 : busy1;
                if (txNow === expBit) good++;
                if (busyNow === 1'b1) busyGood++;
                @(negedge clk);
            end
            check($sformatf("%s bit%0d", tag, k), good, DIV);
        end
        check($sformatf("%s busy cycles", tag), busyGood, nBits * DIV);
    endtask

    // Counts cycles where dut1 is quiet (line high, not busy).
    task automatic watchQuiet(input int cycles, input string tag);
        int quiet;
        quiet = 0;
        for (int c = 0; c < cycles; c++) begin
            if (tx1 === 1'b1 && busy1 === 1'b0) quiet++;
            @(negedge clk);
        end
        check(tag, quiet, cycles);
    endtask

    logic [7:0] fillVals [9];

    initial begin
        fillVals[0] = 8'h01; fillVals[1] = 8'h23; fillVals[2] = 8'h45;
        fillVals[3] = 8'h67; fillVals[4] = 8'h89; fillVals[5] = 8'hAB;
        fillVals[6] = 8'hCD; fillVals[7] = 8'hEF; fillVals[8] = 8'h99;

        rst_n   = 1'b0;
        active1 = 1'b1; valid1 = 1'b0; data1 = 8'h00;
        active2 = 1'b1; valid2 = 1'b0; data2 = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst tx", int'(tx1), 1);
        check("rst busy", int'(busy1), 0);
        check("rst level", int'(level1), 0);
        check("rst ready", int'(ready1), 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte 0x55: accept edge, pop edge, line low after pop edge
        data1 = 8'h55; valid1 = 1'b1;
        @(negedge clk);
        valid1 = 1'b0;
        check("t1 level after push", int'(level1), 1);
        check("t1 tx before pop", int'(tx1), 1);
        check("t1 busy before pop", int'(busy1), 0);
        @(negedge clk);
        check("t1 level after pop", int'(level1), 0);
        watchFrame(1, 8'h55, 1, "t1 0x55");
        check("t1 tx idle after", int'(tx1), 1);
        check("t1 busy after", int'(busy1), 0);
        repeat (4) @(negedge clk);

        // Back-to-back 0xA5, 0x3C: second push coincides with first pop
        data1 = 8'hA5; valid1 = 1'b1;
        @(negedge clk);
        data1 = 8'h3C;
        @(negedge clk);
        valid1 = 1'b0;
        check("t2 level push+pop", int'(level1), 1);
        watchFrame(1, 8'hA5, 1, "t2 0xA5");
        watchFrame(1, 8'h3C, 1, "t2 0x3C");
        check("t2 busy after", int'(busy1), 0);
        check("t2 level after", int'(level1), 0);
        repeat (4) @(negedge clk);

        // Fill with active low: 9th byte refused
        active1 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            data1 = fillVals[i]; valid1 = 1'b1;
            @(negedge clk);
            check($sformatf("t3 level push%0d", i), int'(level1), (i + 1 < 8) ? i + 1 : 8);
            check($sformatf("t3 ready push%0d", i), int'(ready1), (i + 1 < 8) ? 1 : 0);
        end
        valid1 = 1'b0;
        watchQuiet(20, "t3 quiet while inactive");
        check("t3 level held", int'(level1), 8);

        // Raise active: eight frames in order, ready returns after first pop
        active1 = 1'b1;
        @(negedge clk);
        check("t4 level first pop", int'(level1), 7);
        check("t4 ready first pop", int'(ready1), 1);
        for (int i = 0; i < 8; i++) begin
            watchFrame(1, fillVals[i], 1, $sformatf("t4 byte%0d", i));
        end
        check("t4 level drained", int'(level1), 0);
        watchQuiet(20, "t4 ninth byte never sent");

        // active dropped mid-frame on 0xFF
        active1 = 1'b0;
        data1 = 8'hFF; valid1 = 1'b1;
        @(negedge clk);
        data1 = 8'h11;
        @(negedge clk);
        data1 = 8'h22;
        @(negedge clk);
        valid1 = 1'b0;
        active1 = 1'b1;
        @(negedge clk);
        check("t5 tx start", int'(tx1), 0);
        check("t5 level", int'(level1), 2);
        active1 = 1'b0;
        watchFrame(1, 8'hFF, 1, "t5 0xFF");
        watchQuiet(40, "t5 held while inactive");
        check("t5 level held", int'(level1), 2);
        active1 = 1'b1;
        @(negedge clk);
        watchFrame(1, 8'h11, 1, "t5 0x11");
        watchFrame(1, 8'h22, 1, "t5 0x22");
        check("t5 busy after", int'(busy1), 0);

        // Reset during data bit 3 of 0x00 with one more byte queued
        repeat (3) @(negedge clk);
        data1 = 8'h00; valid1 = 1'b1;
        @(negedge clk);
        data1 = 8'h77;
        @(negedge clk);
        valid1 = 1'b0;
        repeat (70) @(negedge clk);
        check("t6 tx in bit3", int'(tx1), 0);
        check("t6 busy in bit3", int'(busy1), 1);
        check("t6 level in bit3", int'(level1), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6 tx on reset", int'(tx1), 1);
        check("t6 busy on reset", int'(busy1), 0);
        check("t6 level on reset", int'(level1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        watchQuiet(40, "t6 quiet after reset");
        data1 = 8'hC3; valid1 = 1'b1;
        @(negedge clk);
        valid1 = 1'b0;
        @(negedge clk);
        watchFrame(1, 8'hC3, 1, "t6 0xC3");

        // Two stop bits, byte 0x00
        data2 = 8'h00; valid2 = 1'b1;
        @(negedge clk);
        valid2 = 1'b0;
        @(negedge clk);
        watchFrame(2, 8'h00, 2, "t7 0x00 2stop");
        check("t7 busy after", int'(busy2), 0);
        check("t7 tx after", int'(tx2), 1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
